trap_sequencer: RTL

Write-back-stage trap controller for the five-stage RV64 pipeline. It takes the `ExceptPack` that the per-stage exception registers carry down to WB, plus retiring `mret`/`sret`. It then sequences the CSR updates (xepc, xcause, xtval, mstatus) over the single CSR write port, one write per handshake. While it runs it holds the pipeline, and when it finishes it issues a one-cycle flush and PC redirect together with the privilege change.

---
 rtl/trap_sequencer_pkg.sv | 44 ++++
 rtl/trap_sequencer_mstatus_update.sv | 44 ++++
 rtl/trap_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared exception types for the write-back stage: the ExceptPack carried down the pipe,
// the trap sequencer state/kind enums, CSR addresses and mstatus bit positions.
package ExceptStruct;

  typedef struct packed {
    logic        except;
    logic [63:0] epc;
    logic [63:0] ecause;
    logic [63:0] etval;
  } ExceptPack;

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_TVAL,
    W_STATUS,
    REDIRECT
  } TrapState;

  typedef enum logic [1:0] {
    KIND_TRAP_M,
    KIND_TRAP_S,
    KIND_MRET,
    KIND_SRET
  } TrapKind;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  localparam int unsigned SIE_BIT  = 1;
  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned SPIE_BIT = 5;
  localparam int unsigned MPIE_BIT = 7;
  localparam int unsigned SPP_BIT  = 8;
  localparam int unsigned MPP_LO   = 11;
  localparam int unsigned MPP_HI   = 12;

endpackage

// File: rtl/trap_sequencer_mstatus_update.sv
// Combinational next-mstatus / next-privilege for trap entry (M or S) and mret/sret,
// computed from the mstatus snapshot taken when the event was accepted.
module mstatus_update
  import ExceptStruct::*;
(
  input  logic [63:0] mstatus_snap,
  input  logic [1:0]  priv,
  input  TrapKind     kind,
  output logic [63:0] mstatus_next,
  output logic [1:0]  priv_next
);

  always_comb begin
    mstatus_next = mstatus_snap;
    priv_next    = 2'd3;
    case (kind)
      KIND_TRAP_M: begin
        mstatus_next[MPIE_BIT]      = mstatus_snap[MIE_BIT];
        mstatus_next[MIE_BIT]       = 1'b0;
        mstatus_next[MPP_HI:MPP_LO] = priv;
        priv_next                   = 2'd3;
      end
      KIND_TRAP_S: begin
        mstatus_next[SPIE_BIT] = mstatus_snap[SIE_BIT];
        mstatus_next[SIE_BIT]  = 1'b0;
        mstatus_next[SPP_BIT]  = priv[0];
        priv_next              = 2'd1;
      end
      KIND_MRET: begin
        mstatus_next[MIE_BIT]       = mstatus_snap[MPIE_BIT];
        mstatus_next[MPIE_BIT]      = 1'b1;
        mstatus_next[MPP_HI:MPP_LO] = 2'b00;
        priv_next                   = mstatus_snap[MPP_HI:MPP_LO];
      end
      default: begin
        mstatus_next[SIE_BIT]  = mstatus_snap[SPIE_BIT];
        mstatus_next[SPIE_BIT] = 1'b1;
        mstatus_next[SPP_BIT]  = 1'b0;
        priv_next              = {1'b0, mstatus_snap[SPP_BIT]};
      end
    endcase
  end

endmodule

// File: rtl/trap_sequencer.sv
// Write-back trap controller: sequences xepc/xcause/xtval/mstatus writes over the single
// CSR port, stalls the pipe while busy, then issues a one-cycle flush + redirect + priv change.
module trap_sequencer
  import ExceptStruct::*;
#(
  parameter bit MTVEC_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_wb,
  input  ExceptPack   except_wb,
  input  logic        is_mret_wb,
  input  logic        is_sret_wb,
  input  logic [1:0]  priv,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] medeleg_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] stvec_i,
  input  logic [63:0] mepc_i,
  input  logic [63:0] sepc_i,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata,
  input  logic        csr_ready,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        priv_we,
  output logic [1:0]  priv_next
);

  TrapState    state_q, state_d;
  ExceptPack   exc_q;
  logic [1:0]  priv_q;
  logic [63:0] mstatus_q;
  logic [63:0] target_q;
  TrapKind     kind_q;

  logic        take_trap, take_xret, to_s;
  TrapKind     kind_d;
  logic [63:0] target_d;
  logic [63:0] mstatus_next;
  logic [1:0]  priv_next_w;
  logic        s_mode;

  // Event detection and capture values; exceptions outrank a retiring xret.
  always_comb begin
    take_trap = valid_wb & except_wb.except;
    take_xret = valid_wb & (is_mret_wb | is_sret_wb) & ~except_wb.except;
    to_s      = !MTVEC_ONLY && (priv != 2'd3) && !except_wb.ecause[63]
                && medeleg_i[except_wb.ecause[5:0]];
    kind_d    = KIND_TRAP_M;
    target_d  = mtvec_i & ~64'h3;
    if (take_trap) begin
      if (to_s) begin
        kind_d   = KIND_TRAP_S;
        target_d = stvec_i & ~64'h3;
      end
    end else if (is_mret_wb) begin
      kind_d   = KIND_MRET;
      target_d = mepc_i;
    end else begin
      kind_d   = KIND_SRET;
      target_d = sepc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      exc_q     <= '0;
      priv_q    <= 2'd0;
      mstatus_q <= '0;
      target_q  <= '0;
      kind_q    <= KIND_TRAP_M;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (take_trap || take_xret)) begin
        exc_q     <= except_wb;
        priv_q    <= priv;
        mstatus_q <= mstatus_i;
        target_q  <= target_d;
        kind_q    <= kind_d;
      end
    end
  end

  mstatus_update u_mstatus_update (
    .mstatus_snap (mstatus_q),
    .priv         (priv_q),
    .kind         (kind_q),
    .mstatus_next (mstatus_next),
    .priv_next    (priv_next_w)
  );

  assign s_mode = (kind_q == KIND_TRAP_S);

  // Each write state holds its request stable until the CSR file accepts it.
  always_comb begin
    state_d        = state_q;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    flush_o        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    priv_we        = 1'b0;
    priv_next      = 2'd0;
    stall_o        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (take_trap)      state_d = W_EPC;
        else if (take_xret) state_d = W_STATUS;
      end
      W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = s_mode ? CSR_SEPC : CSR_MEPC;
        csr_wdata = exc_q.epc;
        if (csr_ready) state_d = W_CAUSE;
      end
      W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = s_mode ? CSR_SCAUSE : CSR_MCAUSE;
        csr_wdata = exc_q.ecause;
        if (csr_ready) state_d = W_TVAL;
      end
      W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = s_mode ? CSR_STVAL : CSR_MTVAL;
        csr_wdata = exc_q.etval;
        if (csr_ready) state_d = W_STATUS;
      end
      W_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_next;
        if (csr_ready) state_d = REDIRECT;
      end
      REDIRECT: begin
        flush_o        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        priv_we        = 1'b1;
        priv_next      = priv_next_w;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
